seq_detect_param: RTL and testbench
===================================

Name: seq_detect_param

Overview:
Parametrised serial pattern detector. It generalises the fixed-pattern Mealy detector to a runtime-programmable pattern of 1..PAT_W bits. Output timing is selectable between Mealy and Moore, and overlapping detection can be switched on or off. It also gates input with a valid strobe and keeps a saturating match counter. It sits on a serial bit stream (UART/line decoder side) and flags frame markers to downstream control.

Parameters:
PAT_W, 8, maximum pattern length in bits (>=2)
LEN_W, 4, width of length field; must hold PAT_W
CNT_W, 8, width of saturating match counter

Ports:
i_clk  input  1  clock, all logic on rising edge
i_rst  input  1  synchronous active-high reset
i_cfg_we  input  1  config write strobe; latches i_pat/i_len/i_overlap/i_moore
i_pat  input  PAT_W  pattern; bit i_len-1 = first bit received, bit 0 = last
i_len  input  LEN_W  pattern length
i_overlap  input  1  1 = overlapping matches allowed
i_moore  input  1  1 = Moore (registered) output, 0 = Mealy
i_en  input  1  i_seq valid this cycle
i_seq  input  1  serial data bit
i_cnt_clr  input  1  clear match counter
o_match  output  1  match flag, one cycle per detected occurrence
o_cnt  output  CNT_W  saturating count of matches
o_fill  output  LEN_W  number of valid history bits held (debug/verification)

Behaviour:
- Reset (i_rst=1 at clock edge):
  - cfg_pat=0, cfg_len=0, cfg_overlap=0, cfg_moore=0.
  - hist=0, fill=0, moore_q=0, o_cnt=0.
  - o_match=0 in both modes: Mealy term is gated by cfg_len!=0.
  - Reset mid-stream discards partial history; the next match needs a full pattern after reset.
- Config:
  - On i_cfg_we, register all cfg fields.
  - i_len > PAT_W is clamped to PAT_W. i_len=0 disables detection (o_match never asserts).
  - A config write also clears hist, fill and moore_q in the same edge. Any i_en bit in that cycle is discarded.
- Accepted bit = i_en=1 and i_cfg_we=0. With i_en=0: no state change, Mealy o_match=0.
- Window = {hist[cfg_len-2:0], i_seq}.
- hit = accepted & cfg_len!=0 & fill >= cfg_len-1 & window == cfg_pat[cfg_len-1:0].
  - For cfg_len=1, hit = accepted & i_seq==cfg_pat[0].
- On accepted bit:
  - hist <= {hist[PAT_W-2:0], i_seq}.
  - If hit & !cfg_overlap: fill <= 0.
  - Otherwise fill <= min(fill+1, PAT_W).
- Mealy (cfg_moore=0): o_match = hit, combinational, same cycle as the completing bit.
- Moore (cfg_moore=1):
  - moore_q <= hit every clock; o_match = moore_q.
  - Asserts exactly one cycle, in the cycle after the completing bit was accepted; deasserts next cycle unless another hit.
- Counter, priority: reset > i_cnt_clr > increment.
  - Increments on hit; saturates at 2^CNT_W-1, no wrap.
  - i_cnt_clr together with a hit gives 0 (the hit is lost).
  - Counting is independent of Moore/Mealy mode.
- Non-overlap restarts the search from the bit after the match. Bits of the matched pattern are never reused.

Test Plan:
- Reset then cfg pat=4'b1011, len=4, overlap=1, Mealy; stream 1,0,1,1,0,1,1 with i_en=1 each cycle -> o_match high combinationally on bits 4 and 7; o_cnt=2.
- Same stream, overlap=0 -> o_match only on bit 4; o_cnt=1; o_fill=3 after bit 7.
- Same as first case with moore=1 -> o_match high the cycle after bits 4 and 7, each exactly one cycle; never in the completing cycle.
- Stream 1,0,1,1 with i_en=0 gaps of 2 cycles between bits -> single match on the last accepted bit; o_match=0 in gap cycles.
- CNT_W=2, pat=2'b11, len=2, overlap=1; stream of six 1s -> five hits, o_cnt saturates at 3. Then i_cnt_clr coincident with a hit -> o_cnt=0.
- Mid-pattern after 1,0,1, pulse i_rst (config reloaded) or i_cfg_we -> o_fill=0. A following single 1 gives no match; a full 1,0,1,1 matches. i_len=12 with PAT_W=8 is clamped to 8; i_len=0 gives no match on any stream.

Source files
------------

// File: rtl/seq_detect_param.sv
// seq_detect_param
// Runtime-programmable serial pattern detector (1..PAT_W bits).
// Selectable Mealy/Moore output timing, optional overlapping matches,
// valid-gated input and a saturating match counter.
//
// Ports:
//   i_clk      clock, all state updates on rising edge
//   i_rst      synchronous active-high reset
//   i_cfg_we   config write strobe (latches i_pat/i_len/i_overlap/i_moore)
//   i_pat      pattern, bit i_len-1 is the first bit received, bit 0 the last
//   i_len      pattern length (clamped to PAT_W, 0 disables detection)
//   i_overlap  1 = overlapping matches allowed
//   i_moore    1 = registered (Moore) match flag, 0 = combinational (Mealy)
//   i_en       i_seq is valid this cycle
//   i_seq      serial data bit
//   i_cnt_clr  clear match counter
//   o_match    one-cycle flag per detected occurrence
//   o_cnt      saturating match count
//   o_fill     number of valid history bits currently held
module seq_detect_param #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cfg_we,
  input  logic [PAT_W-1:0] i_pat,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_overlap,
  input  logic             i_moore,
  input  logic             i_en,
  input  logic             i_seq,
  input  logic             i_cnt_clr,
  output logic             o_match,
  output logic [CNT_W-1:0] o_cnt,
  output logic [LEN_W-1:0] o_fill
);

  localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [PAT_W-1:0] cfg_pat_r;
  logic [LEN_W-1:0] cfg_len_r;
  logic             cfg_overlap_r;
  logic             cfg_moore_r;
  logic [PAT_W-1:0] hist_r;
  logic [LEN_W-1:0] fill_r;
  logic             moore_r;
  logic [CNT_W-1:0] cnt_r;

  logic             accepted_s;
  logic [PAT_W-1:0] window_s;
  logic [PAT_W-1:0] mask_s;
  logic             fill_ok_s;
  logic             hit_s;
  logic [LEN_W-1:0] len_clamp_s;

  // Match detection: compare the newest cfg_len bits (history plus the
  // incoming bit) against the pattern, only once enough history is held.
  always_comb begin
    accepted_s  = i_en & ~i_cfg_we;
    window_s    = {hist_r[PAT_W-2:0], i_seq};
    mask_s      = {PAT_W{1'b0}};
    for (int i = 0; i < PAT_W; i++) begin
      mask_s[i] = (LEN_W'(i) < cfg_len_r);
    end
    // fill >= len-1 written as fill+1 >= len so len=0 cannot underflow
    fill_ok_s   = (({1'b0, fill_r} + {{LEN_W{1'b0}}, 1'b1}) >= {1'b0, cfg_len_r});
    hit_s       = accepted_s && (cfg_len_r != {LEN_W{1'b0}}) && fill_ok_s &&
                  (((window_s ^ cfg_pat_r) & mask_s) == {PAT_W{1'b0}});
    len_clamp_s = (i_len > PAT_W_L) ? PAT_W_L : i_len;
  end

  // Configuration, shift history, fill tracking and Moore flag register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cfg_pat_r     <= {PAT_W{1'b0}};
      cfg_len_r     <= {LEN_W{1'b0}};
      cfg_overlap_r <= 1'b0;
      cfg_moore_r   <= 1'b0;
      hist_r        <= {PAT_W{1'b0}};
      fill_r        <= {LEN_W{1'b0}};
      moore_r       <= 1'b0;
    end else if (i_cfg_we) begin
      // new config restarts the search; any bit offered this cycle is dropped
      cfg_pat_r     <= i_pat;
      cfg_len_r     <= len_clamp_s;
      cfg_overlap_r <= i_overlap;
      cfg_moore_r   <= i_moore;
      hist_r        <= {PAT_W{1'b0}};
      fill_r        <= {LEN_W{1'b0}};
      moore_r       <= 1'b0;
    end else begin
      moore_r <= hit_s;
      if (accepted_s) begin
        hist_r <= {hist_r[PAT_W-2:0], i_seq};
        if (hit_s && !cfg_overlap_r) begin
          // non-overlapping: matched bits are never reused
          fill_r <= {LEN_W{1'b0}};
        end else if (fill_r < PAT_W_L) begin
          fill_r <= fill_r + {{(LEN_W-1){1'b0}}, 1'b1};
        end else begin
          fill_r <= fill_r;
        end
      end else begin
        hist_r <= hist_r;
        fill_r <= fill_r;
      end
    end
  end

  // Saturating match counter; clear wins over a coincident hit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (i_cnt_clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (hit_s && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign o_match = cfg_moore_r ? moore_r : hit_s;
  assign o_cnt   = cnt_r;
  assign o_fill  = fill_r;

endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param
// Directed bench for seq_detect_param (PAT_W=8, LEN_W=4, CNT_W=2).
// Each step pushes its expected match/count/fill into a queue when the
// stimulus is driven; the match flag is compared before the rising edge and
// count/fill are compared just after it, popping the entry.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       i_cfg_we;
  logic [7:0] i_pat;
  logic [3:0] i_len;
  logic       i_overlap;
  logic       i_moore;
  logic       i_en;
  logic       i_seq;
  logic       i_cnt_clr;
  logic       o_match;
  logic [1:0] o_cnt;
  logic [3:0] o_fill;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic       m;
    logic [1:0] c;
    logic [3:0] f;
  } exp_t;

  exp_t exp_q[$];

  seq_detect_param #(.PAT_W(8), .LEN_W(4), .CNT_W(2)) dut (
    .i_clk     (clk),
    .i_rst     (i_rst),
    .i_cfg_we  (i_cfg_we),
    .i_pat     (i_pat),
    .i_len     (i_len),
    .i_overlap (i_overlap),
    .i_moore   (i_moore),
    .i_en      (i_en),
    .i_seq     (i_seq),
    .i_cnt_clr (i_cnt_clr),
    .o_match   (o_match),
    .o_cnt     (o_cnt),
    .o_fill    (o_fill)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One serial step: em is the match flag expected during this cycle,
  // ec/ef the counter and fill expected after the edge.
  task automatic step(input string tag, input logic en, input logic seq, input logic clr,
                      input logic em, input logic [1:0] ec, input logic [3:0] ef);
    exp_t e;
    @(negedge clk);
    i_en = en; i_seq = seq; i_cnt_clr = clr;
    e.tag = tag; e.m = em; e.c = ec; e.f = ef;
    exp_q.push_back(e);
    #2;
    chk({exp_q[0].tag, ".match"}, {7'd0, o_match}, {7'd0, exp_q[0].m});
    @(posedge clk); #1;
    e = exp_q.pop_front();
    chk({e.tag, ".cnt"}, {6'd0, o_cnt}, {6'd0, e.c});
    chk({e.tag, ".fill"}, {4'd0, o_fill}, {4'd0, e.f});
  endtask

  // Config write with a bit offered (must be discarded) and counter clear.
  task automatic cfg(input string tag, input logic [7:0] pat, input logic [3:0] len,
                     input logic ov, input logic mo);
    @(negedge clk);
    i_cfg_we = 1'b1; i_pat = pat; i_len = len; i_overlap = ov; i_moore = mo;
    i_en = 1'b1; i_seq = 1'b1; i_cnt_clr = 1'b1;
    @(posedge clk); #1;
    chk({tag, ".cfg_fill"}, {4'd0, o_fill}, 8'd0);
    chk({tag, ".cfg_cnt"}, {6'd0, o_cnt}, 8'd0);
    @(negedge clk);
    i_cfg_we = 1'b0; i_cnt_clr = 1'b0; i_en = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    i_rst = 1'b1; i_en = 1'b1; i_seq = 1'b1;
    @(posedge clk); #1;
    chk({tag, ".rst_fill"}, {4'd0, o_fill}, 8'd0);
    chk({tag, ".rst_cnt"}, {6'd0, o_cnt}, 8'd0);
    chk({tag, ".rst_match"}, {7'd0, o_match}, 8'd0);
    @(negedge clk);
    i_rst = 1'b0; i_en = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1; i_cfg_we = 1'b0; i_pat = 8'd0; i_len = 4'd0; i_overlap = 1'b0;
    i_moore = 1'b0; i_en = 1'b0; i_seq = 1'b0; i_cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    do_reset("init");

    // overlapping Mealy, pattern 1011
    cfg("t1", 8'b0000_1011, 4'd4, 1'b1, 1'b0);
    step("t1.b1", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'd1);
    step("t1.b2", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd2);
    step("t1.b3", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'd3);
    step("t1.b4", 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 4'd4);
    step("t1.b5", 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 4'd5);
    step("t1.b6", 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 4'd6);
    step("t1.b7", 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 4'd7);

    // non-overlapping: second occurrence shares bit 4, so no match
    cfg("t2", 8'b0000_1011, 4'd4, 1'b0, 1'b0);
    step("t2.b1", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'd1);
    step("t2.b2", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd2);
    step("t2.b3", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'd3);
    step("t2.b4", 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 4'd0);
    step("t2.b5", 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 4'd1);
    step("t2.b6", 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 4'd2);
    step("t2.b7", 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 4'd3);

    // Moore: flag appears the cycle after the completing bit
    cfg("t3", 8'b0000_1011, 4'd4, 1'b1, 1'b1);
    step("t3.b1", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'd1);
    step("t3.b2", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd2);
    step("t3.b3", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'd3);
    step("t3.b4", 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 4'd4);
    step("t3.b5", 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 4'd5);
    step("t3.b6", 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 4'd6);
    step("t3.b7", 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 4'd7);
    step("t3.i1", 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 4'd7);
    step("t3.i2", 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'd7);

    // valid gaps, gap cycles drive 1 which must be ignored
    cfg("t4", 8'b0000_1011, 4'd4, 1'b1, 1'b0);
    step("t4.b1", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'd1);
    step("t4.g1", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd1);
    step("t4.g2", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd1);
    step("t4.b2", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd2);
    step("t4.g3", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd2);
    step("t4.g4", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd2);
    step("t4.b3", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'd3);
    step("t4.g5", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd3);
    step("t4.g6", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd3);
    step("t4.b4", 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 4'd4);
    step("t4.g7", 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 4'd4);

    // counter saturation at 3, clear beats a coincident hit, fill saturates at 8
    cfg("t5", 8'b0000_0011, 4'd2, 1'b1, 1'b0);
    step("t5.b1", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'd1);
    step("t5.b2", 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 4'd2);
    step("t5.b3", 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 4'd3);
    step("t5.b4", 1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 4'd4);
    step("t5.b5", 1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 4'd5);
    step("t5.b6", 1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 4'd6);
    step("t5.clr", 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 4'd7);
    step("t5.b8", 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 4'd8);
    step("t5.b9", 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 4'd8);

    // reset mid-pattern discards history and config
    cfg("t6", 8'b0000_1011, 4'd4, 1'b1, 1'b0);
    step("t6.b1", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'd1);
    step("t6.b2", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd2);
    step("t6.b3", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'd3);
    do_reset("t6");
    cfg("t6r", 8'b0000_1011, 4'd4, 1'b1, 1'b0);
    step("t6.s1", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'd1);
    step("t6.p1", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'd2);
    step("t6.p2", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd3);
    step("t6.p3", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'd4);
    step("t6.p4", 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 4'd5);

    // config write mid-pattern also discards history
    step("t7.b1", 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 4'd6);
    step("t7.b2", 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 4'd7);
    cfg("t7", 8'b0000_1011, 4'd4, 1'b1, 1'b0);
    step("t7.s1", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'd1);
    step("t7.p2", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd2);
    step("t7.p3", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'd3);
    step("t7.p4", 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 4'd4);

    // length 12 clamps to 8: full 8-bit pattern, non-overlapping
    cfg("t8", 8'b1010_0110, 4'd12, 1'b0, 1'b0);
    step("t8.b1", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'd1);
    step("t8.b2", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd2);
    step("t8.b3", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'd3);
    step("t8.b4", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd4);
    step("t8.b5", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd5);
    step("t8.b6", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'd6);
    step("t8.b7", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'd7);
    step("t8.b8", 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 4'd0);

    // length 0 disables detection
    cfg("t9", 8'b0000_0000, 4'd0, 1'b1, 1'b0);
    step("t9.b1", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd1);
    step("t9.b2", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd2);
    step("t9.b3", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd3);
    step("t9.b4", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd4);
    step("t9.b5", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'd5);
    step("t9.b6", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'd6);
    step("t9.b7", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'd7);
    step("t9.b8", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'd8);
    step("t9.b9", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
